// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator, framebuffer fetch with block upscaling and aligned RGB/sync drive.
// Define VGA_TEST_PATTERN_EN to compile in the colour-bar generator selected by test_sel.
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int FB_W        = 160,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              run,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    input  logic              test_sel,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              hsync,
    output logic              vsync,
    output logic              vblank,
    output logic              frame_done,
    output logic              state_dbg
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_AEND = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [HW-1:0]     h_cnt, h_nxt;
    logic [VW-1:0]     v_cnt, v_nxt;
    logic              h_wrap, frame_wrap;
    logic              scan, active, active_nxt;
    logic              hs_raw, vs_raw;
    logic [ADDR_W-1:0] addr_nxt;
    logic              act1, hs1, vs1;
    logic [11:0]       rgb_nxt;

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);
    assign scan       = (state == ST_SCAN);
    assign state_dbg  = state;

    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        case (state)
            ST_STOP: begin
                h_nxt = '0;
                v_nxt = '0;
                if (run) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (h_wrap) begin
                    h_nxt = '0;
                    v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                end else begin
                    h_nxt = h_cnt + HW'(1);
                end
                // A dropped run only takes effect at the frame wrap, so frames are never cut short.
                if (frame_wrap && !run) state_nxt = ST_STOP;
            end
            default: state_nxt = ST_STOP;
        endcase
    end

    assign active     = scan && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign active_nxt = (state_nxt == ST_SCAN) && (h_nxt < H_ACT) && (v_nxt < V_ACT);
    assign addr_nxt   = ADDR_W'((32'(v_nxt) >> SCALE_SHIFT) * 32'(FB_W)
                                + (32'(h_nxt) >> SCALE_SHIFT));

    // Read strobe: the RAM samples rd_addr on the clk edge that ends a cycle with rd_en=1, and
    // rd_data then holds that word until the next strobe. rd_addr already tracks the current
    // counter position, so it is valid whenever rd_en is high.
    assign rd_en      = pix_en && active;
    assign hs_raw     = !(scan && (h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_raw     = !(scan && (v_cnt >= VS_BEG) && (v_cnt < VS_END));
    assign vblank     = (v_cnt >= V_ACT);
    assign frame_done = pix_en && scan && h_wrap && (v_cnt == V_AEND);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_STOP;
            h_cnt   <= '0;
            v_cnt   <= '0;
            rd_addr <= '0;
        end else if (pix_en) begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (active_nxt) rd_addr <= addr_nxt;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  bar_raw, bar1;
    logic [11:0] bar_rgb;

    assign bar_raw = 3'(32'(h_cnt) / 80);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      bar1 <= '0;
        else if (pix_en) bar1 <= bar_raw;
    end

    always_comb begin
        bar_rgb = 12'h000;
        case (bar1)
            3'd0: bar_rgb = 12'hFFF;
            3'd1: bar_rgb = 12'hFF0;
            3'd2: bar_rgb = 12'h0FF;
            3'd3: bar_rgb = 12'h0F0;
            3'd4: bar_rgb = 12'hF0F;
            3'd5: bar_rgb = 12'hF00;
            3'd6: bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    always_comb begin
        rgb_nxt = 12'h000;
        if (act1) rgb_nxt = test_sel ? bar_rgb : rd_data;
    end
`else
    logic unused_test_sel;
    assign unused_test_sel = test_sel;

    always_comb begin
        rgb_nxt = 12'h000;
        if (act1) rgb_nxt = rd_data;
    end
`endif

    // Stage 1 holds the flags of the pixel whose word the RAM is returning; stage 2 drives the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act1                 <= 1'b0;
            hs1                  <= 1'b1;
            vs1                  <= 1'b1;
            {vga_r, vga_g, vga_b} <= 12'h000;
            hsync                <= 1'b1;
            vsync                <= 1'b1;
        end else if (pix_en) begin
            act1                 <= active;
            hs1                  <= hs_raw;
            vs1                  <= vs_raw;
            {vga_r, vga_g, vga_b} <= rgb_nxt;
            hsync                <= hs1;
            vsync                <= vs1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster (56x19 total, 40x12 active) with a 1-clk-latency RAM model.
module tb_vga_scanout;
    localparam int H_ACTIVE = 40;
    localparam int H_TOTAL  = 56;
    localparam int V_ACTIVE = 12;
    localparam int FRAME    = 56 * 19;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        pix_en   = 1'b0;
    logic        run      = 1'b0;
    logic        test_sel = 1'b0;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [11:0] rd_data  = 12'h000;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, vblank, frame_done, state_dbg;
    int          n_cmp    = 0;
    int          n_err    = 0;

    always #5 clk = ~clk;

    // Framebuffer model: each word holds the low 12 bits of its own address.
    always @(posedge clk) if (rd_en) rd_data <= rd_addr[11:0];

    vga_scanout #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .FB_W(160), .SCALE_SHIFT(2), .ADDR_W(15)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .test_sel(test_sel),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .vblank(vblank),
        .frame_done(frame_done), .state_dbg(state_dbg)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want run to complete");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        reset = 1'b0; run = 1'b0; pix_en = 1'b0; test_sel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        #1 reset = 1'b0;
        pix_en = 1'b1; run = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", {vga_r, vga_g, vga_b}); end
        n_cmp++; if ({hsync, vsync} !== 2'b11) begin n_err++; $display("FAIL reset_sync: got %b want 11", {hsync, vsync}); end
        n_cmp++; if ({rd_en, frame_done, vblank} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {rd_en, frame_done, vblank}); end
        n_cmp++; if (rd_addr !== 15'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        n_cmp++; if (state_dbg !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b want 0", state_dbg); end
        run = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (state_dbg !== 1'b0 || rd_en !== 1'b0 || {hsync, vsync} !== 2'b11 || {vga_r, vga_g, vga_b} !== 12'h000) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_stop: got %0d bad clks want 0", bad); end
    endtask

    task automatic test_raster(input int div);
        int k, pos, x, y, hs_f0, hs_f1, hs_low, vs_f0, vs_f1, vs_low;
        int rd_cnt, rd_bad, hold_bad, fd_cnt, fd_first;
        logic [13:0] pins, prev_pins;
        logic [11:0] exp_q[$];
        logic [11:0] exp_rgb;
        logic act;
        apply_reset();
        run = 1'b1;
        k = -1; hs_f0 = -1; hs_f1 = -1; vs_f0 = -1; vs_f1 = -1; hs_low = 0; vs_low = 0;
        rd_cnt = 0; rd_bad = 0; hold_bad = 0; fd_cnt = 0; fd_first = -1;
        prev_pins = {12'h000, 2'b11};
        for (int i = 0; i < H_ACTIVE; i++) exp_q.push_back(12'(i >> 2));
        for (int c = 0; c < 1900 * div; c++) begin
            pix_en = ((c % div) == 0);
            #1;
            if (pix_en && k >= 0) begin
                pos = k % FRAME; x = pos % H_TOTAL; y = pos / H_TOTAL;
                act = (x < H_ACTIVE) && (y < V_ACTIVE);
                if (rd_en !== act) rd_bad++;
                if (rd_en === 1'b1 && k < FRAME) rd_cnt++;
                if (frame_done === 1'b1) begin fd_cnt++; if (fd_first < 0) fd_first = k; end
                if (k == 4 * H_TOTAL + 4) begin n_cmp++; if (rd_addr !== 15'd161) begin n_err++; $display("FAIL div%0d addr_4_4: got %0d want 161", div, rd_addr); end end
                if (k == 3 * H_TOTAL + 3) begin n_cmp++; if (rd_addr !== 15'd0) begin n_err++; $display("FAIL div%0d addr_3_3: got %0d want 0", div, rd_addr); end end
                if (k == 11 * H_TOTAL + 39) begin n_cmp++; if (rd_addr !== 15'd329) begin n_err++; $display("FAIL div%0d addr_last: got %0d want 329", div, rd_addr); end end
                if (k == 12 * H_TOTAL - 1) begin n_cmp++; if (vblank !== 1'b0) begin n_err++; $display("FAIL div%0d vblank_line11: got %b want 0", div, vblank); end end
                if (k == 12 * H_TOTAL) begin n_cmp++; if (vblank !== 1'b1) begin n_err++; $display("FAIL div%0d vblank_line12: got %b want 1", div, vblank); end end
            end else if (rd_en !== 1'b0 || frame_done !== 1'b0) begin
                rd_bad++;
            end
            @(posedge clk);
            if (pix_en) k++;
            @(negedge clk);
            pins = {vga_r, vga_g, vga_b, hsync, vsync};
            if (!pix_en) begin
                if (pins !== prev_pins) hold_bad++;
            end else begin
                if (prev_pins[1] && !hsync) begin if (hs_f0 < 0) hs_f0 = k; else if (hs_f1 < 0) hs_f1 = k; end
                if (prev_pins[0] && !vsync) begin if (vs_f0 < 0) vs_f0 = k; else if (vs_f1 < 0) vs_f1 = k; end
                if (hsync === 1'b0 && k < H_TOTAL + 2) hs_low++;
                if (vsync === 1'b0 && k < FRAME + 2) vs_low++;
                if (k >= 2 && k < H_ACTIVE + 2) begin
                    exp_rgb = exp_q.pop_front();
                    n_cmp++; if (pins[13:2] !== exp_rgb) begin n_err++; $display("FAIL div%0d pixel_x%0d: got %h want %h", div, k - 2, pins[13:2], exp_rgb); end
                end
                if (k == H_ACTIVE + 2 || k == 47) begin n_cmp++; if (pins[13:2] !== 12'h000) begin n_err++; $display("FAIL div%0d blank_k%0d: got %h want 000", div, k, pins[13:2]); end end
                if (k == 230) begin n_cmp++; if (pins[13:2] !== 12'h0A1) begin n_err++; $display("FAIL div%0d pixel_4_4: got %h want 0a1", div, pins[13:2]); end end
                if (k == 657) begin n_cmp++; if (pins[13:2] !== 12'h149) begin n_err++; $display("FAIL div%0d pixel_last: got %h want 149", div, pins[13:2]); end end
            end
            prev_pins = pins;
        end
        n_cmp++; if (hs_f0 !== 46) begin n_err++; $display("FAIL div%0d hsync_start: got %0d want 46", div, hs_f0); end
        n_cmp++; if (hs_low !== 8) begin n_err++; $display("FAIL div%0d hsync_width: got %0d want 8", div, hs_low); end
        n_cmp++; if (hs_f1 - hs_f0 !== H_TOTAL) begin n_err++; $display("FAIL div%0d line_period: got %0d want %0d", div, hs_f1 - hs_f0, H_TOTAL); end
        n_cmp++; if (vs_f0 !== 786) begin n_err++; $display("FAIL div%0d vsync_start: got %0d want 786", div, vs_f0); end
        n_cmp++; if (vs_low !== 2 * H_TOTAL) begin n_err++; $display("FAIL div%0d vsync_width: got %0d want %0d", div, vs_low, 2 * H_TOTAL); end
        n_cmp++; if (vs_f1 - vs_f0 !== FRAME) begin n_err++; $display("FAIL div%0d frame_period: got %0d want %0d", div, vs_f1 - vs_f0, FRAME); end
        n_cmp++; if (rd_cnt !== H_ACTIVE * V_ACTIVE) begin n_err++; $display("FAIL div%0d rd_count: got %0d want %0d", div, rd_cnt, H_ACTIVE * V_ACTIVE); end
        n_cmp++; if (rd_bad !== 0) begin n_err++; $display("FAIL div%0d rd_outside_active: got %0d want 0", div, rd_bad); end
        n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL div%0d hold_between_ticks: got %0d want 0", div, hold_bad); end
        n_cmp++; if (fd_cnt !== 2) begin n_err++; $display("FAIL div%0d frame_done_count: got %0d want 2", div, fd_cnt); end
        n_cmp++; if (fd_first !== 671) begin n_err++; $display("FAIL div%0d frame_done_tick: got %0d want 671", div, fd_first); end
    endtask

    task automatic test_stop();
        int k, fd_cnt, bad;
        apply_reset();
        run = 1'b1; pix_en = 1'b1;
        k = -1; fd_cnt = 0; bad = 0;
        for (int c = 0; c < FRAME + 200; c++) begin
            #1;
            if (k == 5 * H_TOTAL) run = 1'b0;
            if (k >= 5 * H_TOTAL && frame_done === 1'b1) fd_cnt++;
            if (k >= FRAME && rd_en !== 1'b0) bad++;
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == FRAME - 1) begin n_cmp++; if (state_dbg !== 1'b1) begin n_err++; $display("FAIL stop_frame_completes: got %b want 1", state_dbg); end end
            if (k >= FRAME && state_dbg !== 1'b0) bad++;
            if (k >= FRAME + 2 && ({hsync, vsync} !== 2'b11 || {vga_r, vga_g, vga_b} !== 12'h000)) bad++;
        end
        n_cmp++; if (fd_cnt !== 1) begin n_err++; $display("FAIL stop_frame_done: got %0d want 1", fd_cnt); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stop_idle_outputs: got %0d bad clks want 0", bad); end
        n_cmp++; if (vblank !== 1'b0) begin n_err++; $display("FAIL stop_vblank: got %b want 0", vblank); end
    endtask

    task automatic test_reset_mid();
        int k;
        apply_reset();
        run = 1'b1; pix_en = 1'b1; k = -1;
        for (int c = 0; c < 256 && k < 254; c++) begin @(posedge clk); k++; @(negedge clk); end
        n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h0A7) begin n_err++; $display("FAIL mid_pre_rgb: got %h want 0a7", {vga_r, vga_g, vga_b}); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL mid_rgb: got %h want 000", {vga_r, vga_g, vga_b}); end
        n_cmp++; if ({rd_en, state_dbg} !== 2'b00) begin n_err++; $display("FAIL mid_state: got %b want 00", {rd_en, state_dbg}); end
        n_cmp++; if (rd_addr !== 15'd0) begin n_err++; $display("FAIL mid_addr: got %0d want 0", rd_addr); end
        apply_reset();
        run = 1'b1; pix_en = 1'b1; k = -1;
        for (int c = 0; c < 60 && k < 50; c++) begin @(posedge clk); k++; @(negedge clk); end
        n_cmp++; if (hsync !== 1'b0) begin n_err++; $display("FAIL mid_pre_hsync: got %b want 0", hsync); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({hsync, vsync} !== 2'b11) begin n_err++; $display("FAIL mid_hsync: got %b want 11", {hsync, vsync}); end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int k;
        apply_reset();
        test_sel = 1'b1; run = 1'b1; pix_en = 1'b1; k = -1;
        for (int c = 0; c < 20 && k < 10; c++) begin @(posedge clk); k++; @(negedge clk); end
        n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin n_err++; $display("FAIL pattern_bar0: got %h want fff", {vga_r, vga_g, vga_b}); end
        #1;
        n_cmp++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL pattern_rd_en: got %b want 1", rd_en); end
    endtask
`endif

    initial begin
        test_reset();
        test_raster(1);
        test_raster(4);
        test_stop();
        test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
